// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage in front of the data-memory wrapper.
// Takes one request at a time, issues a single word-aligned memory access,
// waits LATENCY cycles and returns an extended load result or a store ack.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// are trapped with io_resp_err instead of touching memory).
module lsu_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic        io_req_wr,
    input  logic [31:0] io_req_addr,
    input  logic [31:0] io_req_wdata,
    input  logic [1:0]  io_req_size,
    input  logic        io_req_unsigned,
    output logic        io_resp_valid,
    input  logic        io_resp_ready,
    output logic [31:0] io_resp_rdata,
    output logic        io_resp_err,
    output logic        io_mem_en,
    output logic        io_mem_wr,
    output logic [31:0] io_mem_addr,
    output logic [31:0] io_mem_wdata,
    output logic [3:0]  io_mem_wstrb,
    input  logic [31:0] io_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        turn_q;      // one idle cycle after a response before the next request

    logic        req_fire;
    logic        resp_fire;
    logic        trap;
    logic [1:0]  lane_off;
    logic [31:0] shifted;
    logic [31:0] load_fmt;
    logic [3:0]  strb;
    logic [31:0] wdata_rep;

    assign req_fire  = io_req_valid && io_req_ready;
    assign resp_fire = io_resp_valid && io_resp_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((io_req_size == 2'd1) && io_req_addr[0]) ||
                        (io_req_size[1] && (io_req_addr[1:0] != 2'd0));
    assign trap = misaligned;
`else
    assign trap = 1'b0;
`endif

    // Byte-lane formatting of the latched request: strobes, replicated store data, load extraction
    always_comb begin
        lane_off  = 2'd0;
        strb      = 4'b1111;
        wdata_rep = wdata_q;
        case (size_q)
            2'd0: begin
                lane_off  = addr_q[1:0];
                strb      = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                lane_off  = {addr_q[1], 1'b0};
                strb      = 4'b0011 << {addr_q[1], 1'b0};
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_off  = 2'd0;
                strb      = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
        shifted = io_mem_rdata >> {lane_off, 3'b000};
        case (size_q)
            2'd0:    load_fmt = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
            2'd1:    load_fmt = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    // Next-state logic and response-latency countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_fire) state_d = trap ? RESP : ACCESS;
            end
            ACCESS: begin
                cnt_d   = 4'(LATENCY - 1);
                state_d = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP: begin
                if (resp_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latch and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            turn_q  <= resp_fire;
            if (req_fire) begin
                wr_q    <= io_req_wr;
                addr_q  <= io_req_addr;
                wdata_q <= io_req_wdata;
                size_q  <= io_req_size;
                uns_q   <= io_req_unsigned;
                err_q   <= trap;
                rdata_q <= '0;
            end
            if (state_q == ACCESS) rdata_q <= wr_q ? 32'd0 : load_fmt;
        end
    end

    assign io_req_ready  = (state_q == IDLE) && !turn_q && !reset;
    assign io_resp_valid = (state_q == RESP) && !reset;
    assign io_resp_rdata = rdata_q;
    assign io_resp_err   = err_q;
    assign io_mem_en     = (state_q == ACCESS) && !reset;
    assign io_mem_wr     = io_mem_en && wr_q;
    assign io_mem_addr   = {addr_q[31:2], 2'b00};
    assign io_mem_wdata  = wdata_rep;
    assign io_mem_wstrb  = io_mem_wr ? strb : 4'b0000;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a byte-array reference
// memory; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_lsu_ctrl;
    localparam int LAT = 3;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic        io_req_wr = 1'b0;
    logic [31:0] io_req_addr = '0;
    logic [31:0] io_req_wdata = '0;
    logic [1:0]  io_req_size = '0;
    logic        io_req_unsigned = 1'b0;
    logic        io_resp_valid;
    logic        io_resp_ready = 1'b0;
    logic [31:0] io_resp_rdata;
    logic        io_resp_err;
    logic        io_mem_en;
    logic        io_mem_wr;
    logic [31:0] io_mem_addr;
    logic [31:0] io_mem_wdata;
    logic [3:0]  io_mem_wstrb;
    logic [31:0] io_mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_wr(io_req_wr), .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata),
        .io_req_size(io_req_size), .io_req_unsigned(io_req_unsigned),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
        .io_resp_rdata(io_resp_rdata), .io_resp_err(io_resp_err),
        .io_mem_en(io_mem_en), .io_mem_wr(io_mem_wr), .io_mem_addr(io_mem_addr),
        .io_mem_wdata(io_mem_wdata), .io_mem_wstrb(io_mem_wstrb), .io_mem_rdata(io_mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory wrapper stand-in plus access/fire monitors
    logic [31:0] mem [64] = '{default: 32'd0};
    assign io_mem_rdata = mem[io_mem_addr[7:2]];

    int          cyc = 0;
    int          en_cnt = 0, en_cyc = 0, fire_cnt = 0;
    int          fire_at [8];
    logic [3:0]  en_strb;
    logic [31:0] en_wdata;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && io_req_valid && io_req_ready) begin
            fire_at[fire_cnt % 8] <= cyc;
            fire_cnt <= fire_cnt + 1;
        end
        if (io_mem_en) begin
            en_cnt   <= en_cnt + 1;
            en_cyc   <= cyc;
            en_strb  <= io_mem_wstrb;
            en_wdata <= io_mem_wdata;
            if (io_mem_wr)
                for (int l = 0; l < 4; l++)
                    if (io_mem_wstrb[l]) mem[io_mem_addr[7:2]][8*l +: 8] <= io_mem_wdata[8*l +: 8];
        end
    end

    // Reference model: little-endian byte memory, naturally aligned accesses
    logic [7:0] refm [256];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a, input logic [1:0] s);
        return a - (a % nbytes(s));
    endfunction

    function automatic logic exp_trap(input logic [31:0] a, input logic [1:0] s);
        return TRAP && ((a % nbytes(s)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        int n = nbytes(s);
        logic [31:0] b = base_of(a, s);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(refm[int'(b[7:0]) + k]) << (8 * k));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] b = base_of(a, s);
        logic [3:0] m = '0;
        for (int k = 0; k < nbytes(s); k++) m[int'(b[1:0]) + k] = 1'b1;
        return m;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s);
        logic [31:0] b = base_of(a, s);
        for (int k = 0; k < nbytes(s); k++) refm[int'(b[7:0]) + k] = wd[8*k +: 8];
    endtask

    // Drives one request, waits for the response (holding it 'hold' cycles), reports observations
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input int hold,
                           output logic [31:0] rdata, output logic err, output int resp_lat,
                           output int en_delta, output int en_lat, output logic [3:0] strb,
                           output logic [31:0] mwdata, output logic stable, output logic tmo);
        int n, f, e0;
        logic [31:0] d0;
        logic er0;
        tmo = 1'b0; stable = 1'b1; rdata = '0; err = 1'b0; resp_lat = -1;
        io_req_valid = 1'b1; io_req_wr = wr; io_req_addr = addr;
        io_req_wdata = wdata; io_req_size = size; io_req_unsigned = uns;
        n = 0;
        while (!io_req_ready && n < 20) begin @(negedge clock); n++; end
        if (!io_req_ready) tmo = 1'b1;
        f = cyc; e0 = en_cnt;
        @(negedge clock);
        io_req_valid = 1'b0;
        n = 0;
        while (!io_resp_valid && n < 40) begin @(negedge clock); n++; end
        if (!io_resp_valid) tmo = 1'b1;
        resp_lat = cyc - f;
        d0 = io_resp_rdata; er0 = io_resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (!io_resp_valid || io_req_ready || io_resp_rdata !== d0 || io_resp_err !== er0) stable = 1'b0;
        end
        io_resp_ready = 1'b1;
        rdata = io_resp_rdata; err = io_resp_err;
        @(negedge clock);
        io_resp_ready = 1'b0;
        en_delta = en_cnt - e0; en_lat = en_cyc - f; strb = en_strb; mwdata = en_wdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (io_req_ready !== 1'b0 || io_resp_valid !== 1'b0 || io_mem_en !== 1'b0 || io_mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b rv=%b en=%b wr=%b want 0000", io_req_ready, io_resp_valid, io_mem_en, io_mem_wr);
        end
        checks++;
        if (io_mem_addr !== 32'd0 || io_mem_wdata !== 32'd0 || io_mem_wstrb !== 4'd0 || io_resp_rdata !== 32'd0 || io_resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wd=%h st=%b rd=%h err=%b want zeros", io_mem_addr, io_mem_wdata, io_mem_wstrb, io_resp_rdata, io_resp_err);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (io_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", io_req_ready); end
    endtask

    task automatic test_store_byte();
        logic [31:0] rd, mw; logic er, st, to; int rl, ed, el; logic [3:0] sb;
        run_txn(1'b1, 32'h8000_0000, 32'h1122_3344, 2'd2, 1'b0, 0, rd, er, rl, ed, el, sb, mw, st, to);
        ref_store(32'h8000_0000, 32'h1122_3344, 2'd2);
        run_txn(1'b1, 32'h8000_0003, 32'h1234_56A5, 2'd0, 1'b0, 0, rd, er, rl, ed, el, sb, mw, st, to);
        ref_store(32'h8000_0003, 32'h1234_56A5, 2'd0);
        checks++;
        if (sb !== 4'b1000) begin errors++; $display("FAIL sb_strobe got %b want 1000", sb); end
        checks++;
        if (mw !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", mw); end
        checks++;
        if (rd !== 32'd0 || er !== 1'b0 || to) begin errors++; $display("FAIL sb_ack got rd=%h err=%b to=%b want 0 0 0", rd, er, to); end
        run_txn(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 0, rd, er, rl, ed, el, sb, mw, st, to);
        checks++;
        if (rd !== 32'hA522_3344) begin errors++; $display("FAIL sb_readback got %h want a5223344", rd); end
    endtask

    task automatic test_half_sign();
        logic [31:0] rd, mw; logic er, st, to; int rl, ed, el; logic [3:0] sb;
        run_txn(1'b1, 32'h8000_0000, 32'h8001_7FFF, 2'd2, 1'b0, 0, rd, er, rl, ed, el, sb, mw, st, to);
        ref_store(32'h8000_0000, 32'h8001_7FFF, 2'd2);
        run_txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 0, rd, er, rl, ed, el, sb, mw, st, to);
        checks++;
        if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL half_signed got %h want ffff8001", rd); end
        checks++;
        if (sb !== 4'b0000) begin errors++; $display("FAIL load_strobe got %b want 0000", sb); end
        run_txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 0, rd, er, rl, ed, el, sb, mw, st, to);
        checks++;
        if (rd !== 32'h0000_8001) begin errors++; $display("FAIL half_unsigned got %h want 00008001", rd); end
    endtask

    task automatic test_timing();
        logic [31:0] rd, mw; logic er, st, to; int rl, ed, el; logic [3:0] sb;
        run_txn(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 5, rd, er, rl, ed, el, sb, mw, st, to);
        checks++;
        if (to || rl != LAT + 1) begin errors++; $display("FAIL resp_latency got %0d want %0d (to=%b)", rl, LAT + 1, to); end
        checks++;
        if (ed != 1 || el != 1) begin errors++; $display("FAIL mem_en_timing got count=%0d at=+%0d want 1 at +1", ed, el); end
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL resp_hold got stable=%b want 1", st); end
        checks++;
        if (rd !== 32'h8001_7FFF) begin errors++; $display("FAIL hold_data got %h want 80017fff", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, mw; logic er, st, to; int rl, ed, el; logic [3:0] sb;
        run_txn(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 0, rd, er, rl, ed, el, sb, mw, st, to);
        checks++;
        if (TRAP) begin
            if (er !== 1'b1 || rd !== 32'd0 || rl != 1 || ed != 0) begin
                errors++;
                $display("FAIL misalign_trap got err=%b rd=%h lat=%0d en=%0d want 1 0 1 0", er, rd, rl, ed);
            end
        end else begin
            if (er !== 1'b0 || rd !== 32'h8001_7FFF || rl != LAT + 1 || ed != 1) begin
                errors++;
                $display("FAIL misalign_ignore got err=%b rd=%h lat=%0d en=%0d want 0 80017fff %0d 1", er, rd, rl, ed, LAT + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int f0, n;
        f0 = fire_cnt; n = 0;
        io_req_valid = 1'b1; io_req_wr = 1'b0; io_req_addr = 32'h8000_0000; io_req_size = 2'd2;
        io_resp_ready = 1'b1;
        while (fire_cnt < f0 + 3 && n < 60) begin @(negedge clock); n++; end
        io_req_valid = 1'b0;
        repeat (LAT + 4) @(negedge clock);
        io_resp_ready = 1'b0;
        checks++;
        if (fire_cnt < f0 + 3) begin
            errors++; $display("FAIL b2b_timeout got fires=%0d want 3", fire_cnt - f0);
        end else if (fire_at[(f0 + 1) % 8] - fire_at[f0 % 8] != LAT + 3 ||
                     fire_at[(f0 + 2) % 8] - fire_at[(f0 + 1) % 8] != LAT + 3) begin
            errors++;
            $display("FAIL b2b_gap got %0d,%0d want %0d", fire_at[(f0 + 1) % 8] - fire_at[f0 % 8],
                     fire_at[(f0 + 2) % 8] - fire_at[(f0 + 1) % 8], LAT + 3);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n, e0, rv;
        n = 0;
        while (!io_req_ready && n < 20) begin @(negedge clock); n++; end
        io_req_valid = 1'b1; io_req_wr = 1'b0; io_req_addr = 32'h8000_0000; io_req_size = 2'd2;
        @(negedge clock);
        io_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (io_mem_en !== 1'b0 || io_mem_wr !== 1'b0 || io_mem_addr !== 32'd0 || io_mem_wdata !== 32'd0 ||
            io_mem_wstrb !== 4'd0 || io_resp_valid !== 1'b0 || io_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset_outs got en=%b wr=%b a=%h wd=%h st=%b rv=%b rdy=%b want zeros",
                     io_mem_en, io_mem_wr, io_mem_addr, io_mem_wdata, io_mem_wstrb, io_resp_valid, io_req_ready);
        end
        reset = 1'b0;
        e0 = en_cnt;
        @(negedge clock);
        checks++;
        if (io_req_ready !== 1'b1) begin errors++; $display("FAIL midwait_ready got %b want 1", io_req_ready); end
        rv = 0;
        for (int i = 0; i < 8; i++) begin
            if (io_resp_valid) rv++;
            @(negedge clock);
        end
        checks++;
        if (rv != 0 || en_cnt != e0) begin errors++; $display("FAIL midwait_dropped got resp=%0d en=%0d want 0 0", rv, en_cnt - e0); end
    endtask

    task automatic test_random();
        logic [31:0] rd, mw, a, wd, exp; logic er, st, to, wr, u, tr; int rl, ed, el, bad;
        logic [3:0] sb, es; logic [1:0] s; logic [31:0] b;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            run_txn(1'b1, 32'h8000_0000 + 32'(4 * w), wd, 2'd2, 1'b0, 0, rd, er, rl, ed, el, sb, mw, st, to);
            ref_store(32'h8000_0000 + 32'(4 * w), wd, 2'd2);
        end
        bad = 0;
        for (int t = 0; t < 150; t++) begin
            wr = 1'($urandom); a = 32'h8000_0000 | 32'($urandom_range(0, 255));
            wd = $urandom; s = 2'($urandom); u = 1'($urandom);
            tr = exp_trap(a, s);
            exp = (wr || tr) ? 32'd0 : ref_load(a, s, u);
            run_txn(wr, a, wd, s, u, int'($urandom_range(0, 2)), rd, er, rl, ed, el, sb, mw, st, to);
            if (wr && !tr) ref_store(a, wd, s);
            checks++;
            if (to || rd !== exp || er !== tr || st !== 1'b1) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_resp a=%h s=%0d wr=%b u=%b got rd=%h err=%b st=%b to=%b want rd=%h err=%b",
                                       a, s, wr, u, rd, er, st, to, exp, tr);
            end
            checks++;
            if (rl != (tr ? 1 : LAT + 1) || ed != (tr ? 0 : 1)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_timing a=%h s=%0d got lat=%0d en=%0d want lat=%0d en=%0d",
                                       a, s, rl, ed, tr ? 1 : LAT + 1, tr ? 0 : 1);
            end
            if (wr && !tr) begin
                es = ref_strb(a, s); b = base_of(a, s);
                checks++;
                if (sb !== es) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_strobe a=%h s=%0d got %b want %b", a, s, sb, es);
                end
                for (int k = 0; k < nbytes(s); k++) begin
                    checks++;
                    if (mw[8*(int'(b[1:0]) + k) +: 8] !== wd[8*k +: 8]) begin
                        errors++; bad++;
                        if (bad < 10) $display("FAIL rand_lane a=%h s=%0d k=%0d got %h want %h", a, s, k,
                                               mw[8*(int'(b[1:0]) + k) +: 8], wd[8*k +: 8]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refm[i] = 8'd0;
        @(negedge clock);
        test_reset();
        test_store_byte();
        test_half_sign();
        test_timing();
        test_misalign();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage sitting directly upstream of the data-memory wrapper (`mem1`). It accepts one load or store request at a time from the execute stage over a valid/ready handshake, formats it into a single word-aligned memory access (address, replicated write data, byte strobes), and drives the memory port for exactly one cycle. It then applies a configurable response latency and returns the aligned, sign- or zero-extended load result, or a store acknowledge, over a second valid/ready handshake.

## Interface
- `LATENCY`, default 1: cycles from the memory access cycle to `io_resp_valid`; legal range 1..15.

- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `io_req_valid`  in  1  request present
- `io_req_ready`  out  1  block can accept a request
- `io_req_wr`  in  1  1 = store, 0 = load
- `io_req_addr`  in  32  byte address
- `io_req_wdata`  in  32  store data, right-justified
- `io_req_size`  in  2  0 = byte, 1 = half, 2 and 3 = word
- `io_req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `io_resp_valid`  out  1  response present
- `io_resp_ready`  in  1  consumer accepts response
- `io_resp_rdata`  out  32  extended load data; 0 for stores
- `io_resp_err`  out  1  misaligned-access error (see Configuration)
- `io_mem_en`  out  1  memory access strobe
- `io_mem_wr`  out  1  memory write
- `io_mem_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `io_mem_wdata`  out  32  replicated store data
- `io_mem_wstrb`  out  4  byte strobes; 0 for loads
- `io_mem_rdata`  in  32  memory read data, combinational from `io_mem_*`

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: `io_req_ready`=1. On fire (valid & ready), latch wr/addr/wdata/size/unsigned and go to ACCESS. If the request is misaligned and trapping is enabled, go to RESP instead.
- ACCESS: one cycle. `io_mem_en`=1 and `io_mem_wr`=latched wr. For a load, capture the formatted `io_mem_rdata` into the result register. Load counter with `LATENCY-1`. Next state is RESP if `LATENCY`=1, else WAIT.
- WAIT: decrement counter each cycle; at 0, go to RESP.
- RESP: `io_resp_valid`=1 and the data is held stable until `io_resp_ready`. On fire, go to IDLE. A new request is not accepted in the same cycle as the response fire.
- Strobes:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Write data replication:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load formatting:
  - Shift `rdata` right by `addr[1:0]*8`; half uses the `{addr[1],0}` offset.
  - Take the low 8/16/32 bits, then sign- or zero-extend to 32.
- `io_mem_*` outputs are 0 outside ACCESS, apart from `io_mem_addr`/`io_mem_wdata`, which may show the latched values.
- Reset at any state (including ACCESS or mid-WAIT) returns the FSM to IDLE and clears the counter, result and err. The in-flight request is dropped with no response.
- Reset values: all outputs 0; `io_req_ready` is 0 while `reset`=1 and 1 on the first cycle after.

## Timing
- Request fire at cycle N: `io_mem_en`=1 in cycle N+1; `io_resp_valid` first high in cycle N+1+`LATENCY`.
- Trapped misaligned request fired at N: `io_resp_valid` high at N+1, and `io_mem_en` is never asserted.
- Maximum throughput is one request per `LATENCY`+3 cycles with `io_resp_ready` tied high.
- A store is committed in the ACCESS cycle, regardless of when the response is accepted.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, performs no memory access.
  - The response carries `io_resp_err`=1 and `io_resp_rdata`=0.
- Undefined:
  - Misaligned low address bits are ignored (half uses `addr[1]`, word uses the aligned word).
  - `io_resp_err` is constant 0.

## Test plan
- Reset mid-WAIT (`LATENCY`=4, reset at fire+2) -> no `io_resp_valid`; `io_req_ready`=1 on the cycle after reset drops; all `io_mem_*`=0.
- Store byte 0xA5 to 0x80000003, then word load 0x80000000 (memory was 0x11223344) -> `wstrb`=4'b1000, `wdata`=0xA5A5A5A5; load returns 0xA5223344.
- Signed half load at 0x80000002 of word 0x8001_7FFF -> 0xFFFF8001; the same load with unsigned=1 -> 0x00008001.
- `LATENCY`=3, fire at cycle 10 -> `mem_en` only at 11, `resp_valid` at 14; hold `resp_ready`=0 for 5 cycles -> data stable, `req_ready`=0 throughout.
- Word load at 0x80000002 -> with the macro: `err`=1, `rdata`=0, `resp_valid` at fire+1, no `mem_en`; without the macro: returns the word at 0x80000000, `err`=0.
- Back-to-back loads with `resp_ready`=1 (`LATENCY`=1) -> the second fire occurs no earlier than 4 cycles after the first.
